spi_arbiter: RTL
================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of requesters, legal range 2..8.
REQ-002 Parameter DW, default 16: SPI frame width (command byte plus data byte).
REQ-003 Parameter TO_W, default 12: timeout counter width; used only when SPI_ARB_TIMEOUT_EN is defined.
REQ-004 Port iSPI_CLK, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port iRST, input, 1: reset, synchronous and active-high.
REQ-006 Port iREQ, input, NREQ: per-requester request level.
REQ-007 Port iREQ_DATA, input, NREQ*DW: per-requester frame; slice i is bits [i*DW +: DW].
REQ-008 Port oGNT, output, NREQ: one-hot grant, held for the whole transaction.
REQ-009 Port oDONE, output, NREQ: one-cycle completion pulse to the granted requester.
REQ-010 Port oRDATA, output, 8: read-back byte; valid while any oDONE bit is 1.
REQ-011 Port oERR, output, 1: timeout flag; valid while any oDONE bit is 1.
REQ-012 Port oSPI_GO, output, 1: start level to the SPI engine.
REQ-013 Port oP2S_DATA, output, DW: frame to the SPI engine.
REQ-014 Port iSPI_END, input, 1: SPI engine end flag.
REQ-015 Port iS2P_DATA, input, 8: SPI engine read byte.

Function
REQ-016 States: IDLE, XFER, RELEASE; encoded state register.
REQ-017 IDLE, any iREQ bit set: pick a winner round-robin and latch it as one-hot oGNT.
  - Latch oP2S_DATA from the winner's slice.
  - Set oSPI_GO to 1 and go to XFER, all on the same edge.
REQ-018 Round-robin rule: search starts at index ptr, wrapping NREQ-1 to 0; first set bit wins.
  - ptr is set to winner+1 mod NREQ at grant time.
REQ-019 XFER with iSPI_END=1, on one edge:
  - Clear oSPI_GO.
  - Register iS2P_DATA into oRDATA.
  - Pulse the oDONE bit of the granted requester for exactly 1 cycle.
  - Go to RELEASE.
REQ-020 RELEASE: hold oGNT; go to IDLE (clearing oGNT) on the first cycle iSPI_END=0.
REQ-021 Each requester holds iREQ and its data stable from assertion until its oDONE.
  - It deasserts iREQ no later than the cycle after oDONE; a level still high in IDLE counts as a new request.
REQ-022 Minimum spacing between successive oSPI_GO rising edges is 3 cycles (IDLE, XFER, RELEASE).
REQ-023 iREQ changes during XFER/RELEASE do not affect the current grant or oP2S_DATA.
REQ-024 A requester deasserting iREQ while granted is ignored; the transaction completes and oDONE still pulses.
REQ-025 oGNT is at most one-hot at all times; oDONE is only ever set on the bit set in oGNT.
REQ-026 oERR=0 on every normal completion.

Reset
REQ-027 Reset values, applied on the edge where iRST=1 regardless of state (including mid-XFER):
  - oGNT=0, oDONE=0, oSPI_GO=0, oP2S_DATA=0, oRDATA=0, oERR=0.
  - ptr=0, state=IDLE, timeout counter=0.
REQ-028 A transaction interrupted by reset produces no oDONE.

Configuration
REQ-029 Macro SPI_ARB_TIMEOUT_EN compiles in a watchdog.
REQ-030 When defined:
  - A TO_W-bit counter clears on entry to XFER and increments each XFER cycle.
  - When it reaches all-ones with iSPI_END=0: clear oSPI_GO, pulse oDONE, set oERR=1, set oRDATA=8'h00, go to RELEASE.
REQ-031 When undefined: no counter is built, oERR is tied to 0, and XFER waits indefinitely for iSPI_END.

Structure
REQ-032 Shared package spi_arb_pkg holds:
  - the state encoding (IDLE, XFER, RELEASE);
  - the default DW, NREQ and TO_W constants;
  - the read-mode and write-mode command-bit constants used to build frames.
REQ-033 Sub-module rr_pick: combinational round-robin picker.
  - Inputs: request vector, ptr.
  - Outputs: one-hot winner, winner index, any-request.
REQ-034 Everything else stays in spi_arbiter.

Verification
REQ-035 Scenario 1, single request: iREQ=3'b001, data 16'h2D08, engine raises END 20 cycles after GO.
  - Required: oP2S_DATA=16'h2D08; oDONE=3'b001 for 1 cycle; oRDATA equals iS2P_DATA at END; oERR=0.
REQ-036 Scenario 2, fairness: all three requesters held high continuously from reset.
  - Required: grant order 0,1,2,0,1,2; no oGNT overlap; GO edges at least 3 cycles apart.
REQ-037 Scenario 3, arrival during XFER: iREQ=3'b010 active, then iREQ[0] rises mid-XFER.
  - Required: grant 1 completes undisturbed; requester 0 is granted on the next IDLE.
REQ-038 Scenario 4, reset mid-XFER: iRST=1 pulsed in XFER.
  - Required: next cycle oSPI_GO=0, oGNT=0, no oDONE, ptr=0; the next request from index 0 wins first.
REQ-039 Scenario 5, timeout with SPI_ARB_TIMEOUT_EN and TO_W=4: END never asserted.
  - Required: oDONE pulses 15 cycles after entering XFER, with oERR=1 and oRDATA=8'h00.
REQ-040 Scenario 6, no timeout build, END held off 5000 cycles.
  - Required: no oDONE until END arrives; oERR stays 0.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI bus arbiter: FSM encoding, default sizes and frame helpers.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StXfer    = 2'd1,
        StRelease = 2'd2
    } state_e;

    localparam int unsigned DefNreq = 3;
    localparam int unsigned DefDw   = 16;
    localparam int unsigned DefToW  = 12;

    // MSB of the command byte selects read (1) or write (0)
    localparam logic CmdRead  = 1'b1;
    localparam logic CmdWrite = 1'b0;

    function automatic logic [15:0] mk_frame(input logic       rw,
                                             input logic [6:0] addr,
                                             input logic [7:0] data);
        return {rw, addr, data};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to 0.
module rr_pick #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win_gnt,
    output logic [PW-1:0]   win_idx,
    output logic            win_any
);

    logic [PW:0]   sum;
    logic [PW-1:0] cand;

    always_comb begin
        win_gnt = '0;
        win_idx = '0;
        win_any = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            cand = sum[PW-1:0];
            if (!win_any && req[cand]) begin
                win_any       = 1'b1;
                win_gnt[cand] = 1'b1;
                win_idx       = cand;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI engine among NREQ requesters.
// Define SPI_ARB_TIMEOUT_EN to build the XFER watchdog (TO_W-bit counter, oERR on expiry).
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NREQ = DefNreq,
    parameter int unsigned DW   = DefDw,
    parameter int unsigned TO_W = DefToW
) (
    input  logic              iSPI_CLK,
    input  logic              iRST,
    input  logic [NREQ-1:0]   iREQ,
    input  logic [NREQ*DW-1:0] iREQ_DATA,
    output logic [NREQ-1:0]   oGNT,
    output logic [NREQ-1:0]   oDONE,
    output logic [7:0]        oRDATA,
    output logic              oERR,
    output logic              oSPI_GO,
    output logic [DW-1:0]     oP2S_DATA,
    input  logic              iSPI_END,
    input  logic [7:0]        iS2P_DATA
);

    localparam int unsigned PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TO_W == 0) begin : g_bad_param
        $error("spi_arbiter: NREQ must be 2..8 and TO_W nonzero");
    end

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
    logic            go_q, go_d;
    logic [DW-1:0]   p2s_q, p2s_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [PW-1:0]   ptr_q, ptr_d;

    logic [NREQ-1:0] win_gnt;
    logic [PW-1:0]   win_idx;
    logic            win_any;
    logic [DW-1:0]   win_data;
    logic            timeout;

`ifdef SPI_ARB_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;

    // Fires on the edge where the counter would reach all-ones
    assign timeout = (state_q == StXfer) && !iSPI_END && ((to_cnt_q + 1'b1) == '1);
    assign oERR    = err_q;
`else
    assign timeout = 1'b0;
    assign oERR    = 1'b0;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req     (iREQ),
        .ptr     (ptr_q),
        .win_gnt (win_gnt),
        .win_idx (win_idx),
        .win_any (win_any)
    );

    always_comb begin
        win_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (win_gnt[i]) begin
                win_data = iREQ_DATA[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge iSPI_CLK) begin
        if (iRST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (win_any) state_d = StXfer;
            StXfer:    if (iSPI_END || timeout) state_d = StRelease;
            StRelease: if (!iSPI_END) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        gnt_d   = gnt_q;
        done_d  = '0;
        go_d    = go_q;
        p2s_d   = p2s_q;
        rdata_d = rdata_q;
        ptr_d   = ptr_q;
`ifdef SPI_ARB_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (win_any) begin
                    gnt_d = win_gnt;
                    p2s_d = win_data;
                    go_d  = 1'b1;
                    ptr_d = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            StXfer: begin
                if (iSPI_END) begin
                    go_d    = 1'b0;
                    rdata_d = iS2P_DATA;
                    done_d  = gnt_q;
`ifdef SPI_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (timeout) begin
                    go_d    = 1'b0;
                    rdata_d = 8'h00;
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
`endif
                end
            end
            StRelease: begin
                if (!iSPI_END) gnt_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iSPI_CLK) begin
        if (iRST) begin
            gnt_q   <= '0;
            done_q  <= '0;
            go_q    <= 1'b0;
            p2s_q   <= '0;
            rdata_q <= '0;
            ptr_q   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            to_cnt_q <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            go_q    <= go_d;
            p2s_q   <= p2s_d;
            rdata_q <= rdata_d;
            ptr_q   <= ptr_d;
`ifdef SPI_ARB_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign oGNT      = gnt_q;
    assign oDONE     = done_q;
    assign oSPI_GO   = go_q;
    assign oP2S_DATA = p2s_q;
    assign oRDATA    = rdata_q;

endmodule
